// File: rtl/ctrl_pipe_unit_if.sv
// Control-unit bus: ID-stage instruction fields in, pipelined control out.
// The master drives the ID side; the slave is the control unit.
interface ctrl_pipe_unit_if #(
    parameter int OPW  = 4,
    parameter int RW   = 4,
    parameter int CNTW = 16
);
    logic            id_valid;
    logic [OPW-1:0]  id_opcode;
    logic [RW-1:0]   id_rs;
    logic [RW-1:0]   id_rt;
    logic [RW-1:0]   id_rd;
    logic            ex_zero;
    logic            stall;
    logic            flush;
    logic [3:0]      ex_aluop;
    logic            ex_alusrc;
    logic            ex_regdst;
    logic            ex_branch;
    logic            mem_read;
    logic            mem_write;
    logic            wb_wen;
    logic            wb_memtoreg;
    logic [RW-1:0]   wb_waddr;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd, ex_zero,
        input  stall, flush, ex_aluop, ex_alusrc, ex_regdst, ex_branch,
        input  mem_read, mem_write, wb_wen, wb_memtoreg, wb_waddr,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_rd, ex_zero,
        output stall, flush, ex_aluop, ex_alusrc, ex_regdst, ex_branch,
        output mem_read, mem_write, wb_wen, wb_memtoreg, wb_waddr,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: ID decode, ID/EX..MEM/WB control registers,
// load-use stall, taken-branch flush and saturating event counters.
module ctrl_pipe_unit #(
    parameter int OPW         = 4,
    parameter int RW          = 4,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNTW        = 16
) (
    input logic           clk,
    input logic           rst_n,
    ctrl_pipe_unit_if.slave bus
);
    typedef struct packed {
        logic [3:0]    aluop;
        logic          alusrc;
        logic          regdst;
        logic          branch;
        logic          mem_read;
        logic          mem_write;
        logic          wen;
        logic          memtoreg;
        logic [RW-1:0] waddr;
    } id_ex_t;

    typedef struct packed {
        logic          mem_read;
        logic          mem_write;
        logic          wen;
        logic          memtoreg;
        logic [RW-1:0] waddr;
    } ex_mem_t;

    typedef struct packed {
        logic          wen;
        logic          memtoreg;
        logic [RW-1:0] waddr;
    } mem_wb_t;

    localparam int SQW = 2;

    localparam id_ex_t IDEX_BUBBLE = '{
        aluop: 4'd0, alusrc: 1'b0, regdst: 1'b0, branch: 1'b0,
        mem_read: 1'b0, mem_write: 1'b0, wen: 1'b0,
        memtoreg: 1'b1, waddr: '0
    };
    localparam ex_mem_t EXMEM_BUBBLE = '{
        mem_read: 1'b0, mem_write: 1'b0, wen: 1'b0,
        memtoreg: 1'b1, waddr: '0
    };
    localparam mem_wb_t MEMWB_BUBBLE = '{
        wen: 1'b0, memtoreg: 1'b1, waddr: '0
    };

    id_ex_t           id_ex;
    id_ex_t           id_ex_d;
    id_ex_t           dec;
    ex_mem_t          ex_mem;
    mem_wb_t          mem_wb;
    logic [SQW-1:0]   squash;
    logic [CNTW-1:0]  stall_cnt;
    logic [CNTW-1:0]  flush_cnt;

    logic [3:0] op4;
    logic       op_ok;
    logic       is_alu;
    logic       is_sh;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       uses_rt;
    logic       haz;
    logic       taken;
    logic       flush;
    logic       stall;

    assign op4    = bus.id_opcode[3:0];
    assign op_ok  = (bus.id_opcode >> 4) == '0;
    assign is_alu = op_ok & ((op4[3:2] == 2'b00) | (op4[3:1] == 3'b011));
    assign is_sh  = op_ok & (op4[3:1] == 3'b010);
    assign is_lw  = op_ok & (op4 == 4'b1000);
    assign is_sw  = op_ok & (op4 == 4'b1001);
    assign is_beq = op_ok & (op4 == 4'b1010);

    always_comb begin
        dec     = IDEX_BUBBLE;
        uses_rt = 1'b0;
        unique case (1'b1)
            is_alu: begin
                dec.aluop = op4;
                dec.wen   = 1'b1;
                dec.waddr = bus.id_rd;
                uses_rt   = 1'b1;
            end
            is_sh: begin
                dec.aluop  = op4;
                dec.wen    = 1'b1;
                dec.alusrc = 1'b1;
                dec.waddr  = bus.id_rd;
            end
            is_lw: begin
                dec.wen      = 1'b1;
                dec.alusrc   = 1'b1;
                dec.mem_read = 1'b1;
                dec.memtoreg = 1'b0;
                dec.waddr    = bus.id_rt;
            end
            is_sw: begin
                dec.alusrc    = 1'b1;
                dec.mem_write = 1'b1;
                dec.regdst    = 1'b1;
                uses_rt       = 1'b1;
            end
            is_beq: begin
                dec.branch = 1'b1;
                dec.regdst = 1'b1;
                uses_rt    = 1'b1;
            end
            default: ;
        endcase
        // r0 is hardwired; never let a write to it reach the regfile
        if (dec.waddr == '0) dec.wen = 1'b0;
    end

    always_comb begin
        haz = bus.id_valid & id_ex.mem_read & (id_ex.waddr != '0) &
              ((id_ex.waddr == bus.id_rs) |
               ((id_ex.waddr == bus.id_rt) & uses_rt));
        taken = id_ex.branch & bus.ex_zero;
        flush = taken | (squash != '0);
        stall = haz & ~flush;
        id_ex_d = dec;
        if (!bus.id_valid || haz || flush) id_ex_d = IDEX_BUBBLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex  <= IDEX_BUBBLE;
            ex_mem <= EXMEM_BUBBLE;
            mem_wb <= MEMWB_BUBBLE;
        end else begin
            id_ex  <= id_ex_d;
            ex_mem <= '{
                mem_read:  id_ex.mem_read,
                mem_write: id_ex.mem_write,
                wen:       id_ex.wen,
                memtoreg:  id_ex.memtoreg,
                waddr:     id_ex.waddr
            };
            mem_wb <= '{
                wen:      ex_mem.wen,
                memtoreg: ex_mem.memtoreg,
                waddr:    ex_mem.waddr
            };
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash <= '0;
        end else if (taken) begin
            squash <= SQW'(FLUSH_DEPTH - 1);
        end else if (squash != '0) begin
            squash <= squash - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNTW'(1);
            if (taken && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNTW'(1);
        end
    end

    assign bus.stall       = stall;
    assign bus.flush       = flush;
    assign bus.ex_aluop    = id_ex.aluop;
    assign bus.ex_alusrc   = id_ex.alusrc;
    assign bus.ex_regdst   = id_ex.regdst;
    assign bus.ex_branch   = id_ex.branch;
    assign bus.mem_read    = ex_mem.mem_read;
    assign bus.mem_write   = ex_mem.mem_write;
    assign bus.wb_wen      = mem_wb.wen;
    assign bus.wb_memtoreg = mem_wb.memtoreg;
    assign bus.wb_waddr    = mem_wb.waddr;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: directed scenarios plus a random run
// against an instruction-level model; a CNTW=2 copy shares the stimulus.
module tb_ctrl_pipe_unit;
    localparam int FD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ctrl_pipe_unit_if #(.OPW(4), .RW(4), .CNTW(16)) b1 ();
    ctrl_pipe_unit_if #(.OPW(4), .RW(4), .CNTW(2))  b2 ();

    assign b2.id_valid  = b1.id_valid;
    assign b2.id_opcode = b1.id_opcode;
    assign b2.id_rs     = b1.id_rs;
    assign b2.id_rt     = b1.id_rt;
    assign b2.id_rd     = b1.id_rd;
    assign b2.ex_zero   = b1.ex_zero;

    ctrl_pipe_unit #(.OPW(4), .RW(4), .FLUSH_DEPTH(FD), .CNTW(16)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave)
    );
    ctrl_pipe_unit #(.OPW(4), .RW(4), .FLUSH_DEPTH(FD), .CNTW(2)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave)
    );

    // One in-flight instruction as seen from the control outputs
    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       regdst;
        logic       branch;
        logic       mrd;
        logic       mwr;
        logic       wen;
        logic       m2r;
        logic [3:0] waddr;
    } rec_t;

    rec_t m_pipe [3];
    int   m_sq;
    int   m_sc;
    int   m_sc2;
    int   m_fc;

    function automatic rec_t bubble();
        rec_t r = '0;
        r.m2r = 1'b1;
        return r;
    endfunction

    function automatic rec_t m_dec(int op, int rt, int rd);
        rec_t r = bubble();
        if (op inside {[0:3], 6, 7}) begin
            r.aluop = 4'(op); r.wen = 1'b1; r.waddr = 4'(rd);
        end else if (op == 4 || op == 5) begin
            r.aluop = 4'(op); r.wen = 1'b1; r.alusrc = 1'b1;
            r.waddr = 4'(rd);
        end else if (op == 8) begin
            r.wen = 1'b1; r.alusrc = 1'b1; r.mrd = 1'b1;
            r.m2r = 1'b0; r.waddr = 4'(rt);
        end else if (op == 9) begin
            r.alusrc = 1'b1; r.mwr = 1'b1; r.regdst = 1'b1;
        end else if (op == 10) begin
            r.branch = 1'b1; r.regdst = 1'b1;
        end
        if (r.waddr == 4'd0) r.wen = 1'b0;
        return r;
    endfunction

    function automatic bit m_uses_rt(int op);
        return op inside {[0:3], 6, 7, 9, 10};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = bubble();
        m_sq = 0; m_sc = 0; m_sc2 = 0; m_fc = 0;
    endtask

    task automatic m_eval(output bit tk, output bit hz,
                          output bit st, output bit fl);
        rec_t ex = m_pipe[0];
        int op = int'(b1.id_opcode);
        int rs = int'(b1.id_rs);
        int rt = int'(b1.id_rt);
        tk = ex.branch && b1.ex_zero;
        hz = b1.id_valid && ex.mrd && ex.waddr != 0 &&
             (int'(ex.waddr) == rs ||
              (int'(ex.waddr) == rt && m_uses_rt(op)));
        fl = tk || m_sq > 0;
        st = hz && !fl;
    endtask

    task automatic m_clock();
        bit tk, hz, st, fl;
        rec_t nx;
        m_eval(tk, hz, st, fl);
        nx = m_dec(int'(b1.id_opcode), int'(b1.id_rt), int'(b1.id_rd));
        if (!b1.id_valid || hz || fl) nx = bubble();
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = nx;
        m_sq = tk ? FD - 1 : (m_sq > 0 ? m_sq - 1 : 0);
        if (st) begin
            m_sc  = (m_sc < 65535) ? m_sc + 1 : m_sc;
            m_sc2 = (m_sc2 < 3) ? m_sc2 + 1 : m_sc2;
        end
        if (tk) m_fc = m_fc + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(bit v, int op, int rs, int rt, int rd, bit z);
        b1.id_valid  = v;
        b1.id_opcode = 4'(op);
        b1.id_rs     = 4'(rs);
        b1.id_rt     = 4'(rt);
        b1.id_rd     = 4'(rd);
        b1.ex_zero   = z;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drv(1, $urandom_range(0, 15), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
            tick();
            got = {b1.stall, b1.flush, b1.ex_aluop, b1.ex_alusrc,
                   b1.ex_regdst, b1.ex_branch, b1.mem_read,
                   b1.mem_write, b1.wb_wen, b1.wb_memtoreg};
            checks++;
            if (got !== 14'b00_0000_000_00_01) begin
                failures++;
                $display("FAIL reset_outs got=%b exp=%b",
                         got, 14'b00_0000_000_00_01);
            end
            checks++;
            if ({b1.wb_waddr, b1.stall_cnt, b1.flush_cnt, b2.stall_cnt}
                !== '0) begin
                failures++;
                $display("FAIL reset_cnt waddr=%0d sc=%0d fc=%0d sc2=%0d",
                         b1.wb_waddr, b1.stall_cnt, b1.flush_cnt,
                         b2.stall_cnt);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw_latency();
        do_reset();
        drv(1, 8, 1, 3, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        checks++;
        if (b1.ex_alusrc !== 1'b1 || b1.mem_read !== 1'b0) begin
            failures++;
            $display("FAIL lw_ex alusrc=%b mrd=%b exp 1 0",
                     b1.ex_alusrc, b1.mem_read);
        end
        tick();
        checks++;
        if (b1.mem_read !== 1'b1 || b1.ex_alusrc !== 1'b0) begin
            failures++;
            $display("FAIL lw_mem mrd=%b alusrc=%b exp 1 0",
                     b1.mem_read, b1.ex_alusrc);
        end
        tick();
        checks++;
        if ({b1.wb_wen, b1.wb_memtoreg, b1.wb_waddr} !== 6'b10_0011) begin
            failures++;
            $display("FAIL lw_wb wen=%b m2r=%b waddr=%0d exp 1 0 3",
                     b1.wb_wen, b1.wb_memtoreg, b1.wb_waddr);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drv(1, 8, 1, 3, 0, 0);
        #1;
        checks++;
        if (b1.stall !== 1'b0) begin
            failures++;
            $display("FAIL lu_pre stall=%b exp 0", b1.stall);
        end
        tick();
        drv(1, 2, 3, 5, 6, 0);
        #1;
        checks++;
        if (b1.stall !== 1'b1) begin
            failures++;
            $display("FAIL lu_stall stall=%b exp 1", b1.stall);
        end
        tick();
        #1;
        checks++;
        if ({b1.stall, b1.ex_aluop, b1.ex_alusrc, b1.mem_read}
            !== 7'b0_0000_0_1) begin
            failures++;
            $display("FAIL lu_bubble st=%b aluop=%0d alusrc=%b mrd=%b",
                     b1.stall, b1.ex_aluop, b1.ex_alusrc, b1.mem_read);
        end
        checks++;
        if (b1.stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL lu_cnt got=%0d exp=1", b1.stall_cnt);
        end
        tick();
        drv(0, 0, 0, 0, 0, 0);
        checks++;
        if (b1.ex_aluop !== 4'd2 || b1.stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL lu_add aluop=%0d sc=%0d exp 2 1",
                     b1.ex_aluop, b1.stall_cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        drv(1, 10, 1, 2, 0, 0);
        tick();
        checks++;
        if (b1.ex_branch !== 1'b1 || b1.ex_regdst !== 1'b1) begin
            failures++;
            $display("FAIL br_ex branch=%b regdst=%b exp 1 1",
                     b1.ex_branch, b1.ex_regdst);
        end
        drv(1, 2, 4, 5, 6, 1);
        #1;
        checks++;
        if (b1.flush !== 1'b1 || b1.stall !== 1'b0) begin
            failures++;
            $display("FAIL br_taken flush=%b stall=%b exp 1 0",
                     b1.flush, b1.stall);
        end
        tick();
        #1;
        checks++;
        if (b1.flush !== 1'b1 || b1.ex_aluop !== 4'd0
            || b1.ex_branch !== 1'b0) begin
            failures++;
            $display("FAIL br_sq1 flush=%b aluop=%0d br=%b exp 1 0 0",
                     b1.flush, b1.ex_aluop, b1.ex_branch);
        end
        tick();
        #1;
        checks++;
        if (b1.flush !== 1'b0 || b1.ex_aluop !== 4'd0
            || b1.flush_cnt !== 16'd1) begin
            failures++;
            $display("FAIL br_sq2 flush=%b aluop=%0d fc=%0d exp 0 0 1",
                     b1.flush, b1.ex_aluop, b1.flush_cnt);
        end
        tick();
        drv(1, 10, 1, 2, 0, 0);
        checks++;
        if (b1.ex_aluop !== 4'd2) begin
            failures++;
            $display("FAIL br_resume aluop=%0d exp 2", b1.ex_aluop);
        end
        tick();
        drv(1, 3, 4, 5, 6, 0);
        #1;
        checks++;
        if (b1.flush !== 1'b0) begin
            failures++;
            $display("FAIL br_nt flush=%b exp 0", b1.flush);
        end
        tick();
        drv(0, 0, 0, 0, 0, 0);
        checks++;
        if (b1.ex_aluop !== 4'd3 || b1.flush_cnt !== 16'd1) begin
            failures++;
            $display("FAIL br_nt_pass aluop=%0d fc=%0d exp 3 1",
                     b1.ex_aluop, b1.flush_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drv(1, 10, 1, 2, 0, 1);
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b1.flush !== 1'b0 || b1.flush_cnt !== '0) begin
            failures++;
            $display("FAIL rst_squash flush=%b fc=%0d exp 0 0",
                     b1.flush, b1.flush_cnt);
        end
        do_reset();
        drv(1, 8, 1, 3, 0, 0);
        tick();
        drv(1, 9, 2, 3, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b1.stall !== 1'b0 || b1.ex_alusrc !== 1'b0) begin
            failures++;
            $display("FAIL rst_stall stall=%b alusrc=%b exp 0 0",
                     b1.stall, b1.ex_alusrc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(1, 8, 1, 3, 0, 0);
            tick();
            drv(1, 0, 3, 2, 4, 0);
            tick();
            drv(0, 0, 0, 0, 0, 0);
            tick();
        end
        checks++;
        if (b2.stall_cnt !== 2'd3 || b1.stall_cnt !== 16'd5) begin
            failures++;
            $display("FAIL sat_cnt sc2=%0d sc=%0d exp 3 5",
                     b2.stall_cnt, b1.stall_cnt);
        end
        drv(1, 1, 1, 2, 0, 0);
        tick();
        drv(1, 1, 1, 2, 7, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (b1.wb_wen !== 1'b0) begin
            failures++;
            $display("FAIL rd0_wen got=%b exp 0", b1.wb_wen);
        end
        tick();
        checks++;
        if (b1.wb_wen !== 1'b1 || b1.wb_waddr !== 4'd7) begin
            failures++;
            $display("FAIL rd7_wen wen=%b waddr=%0d exp 1 7",
                     b1.wb_wen, b1.wb_waddr);
        end
    endtask

    task automatic test_random();
        bit tk, hz, st, fl;
        bit hold = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!hold)
                drv($urandom_range(0, 7) != 0, $urandom_range(0, 15),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'b0);
            b1.ex_zero = 1'($urandom_range(0, 1));
            #1;
            m_eval(tk, hz, st, fl);
            checks++;
            if ({b1.stall, b1.flush} !== {st, fl}) begin
                failures++;
                $display("FAIL rnd_comb cyc=%0d got=%b%b exp=%b%b",
                         c, b1.stall, b1.flush, st, fl);
            end
            checks++;
            if ({b1.ex_aluop, b1.ex_alusrc, b1.ex_regdst, b1.ex_branch}
                !== {m_pipe[0].aluop, m_pipe[0].alusrc,
                     m_pipe[0].regdst, m_pipe[0].branch}) begin
                failures++;
                $display("FAIL rnd_ex cyc=%0d aluop=%0d exp=%0d",
                         c, b1.ex_aluop, m_pipe[0].aluop);
            end
            checks++;
            if ({b1.mem_read, b1.mem_write}
                !== {m_pipe[1].mrd, m_pipe[1].mwr}) begin
                failures++;
                $display("FAIL rnd_mem cyc=%0d got=%b%b exp=%b%b", c,
                         b1.mem_read, b1.mem_write,
                         m_pipe[1].mrd, m_pipe[1].mwr);
            end
            checks++;
            if ({b1.wb_wen, b1.wb_memtoreg, b1.wb_waddr}
                !== {m_pipe[2].wen, m_pipe[2].m2r, m_pipe[2].waddr}) begin
                failures++;
                $display("FAIL rnd_wb cyc=%0d got=%b%b/%0d exp=%b%b/%0d",
                         c, b1.wb_wen, b1.wb_memtoreg, b1.wb_waddr,
                         m_pipe[2].wen, m_pipe[2].m2r, m_pipe[2].waddr);
            end
            checks++;
            if (b1.stall_cnt !== 16'(m_sc) || b1.flush_cnt !== 16'(m_fc)
                || b2.stall_cnt !== 2'(m_sc2)) begin
                failures++;
                $display("FAIL rnd_cnt cyc=%0d sc=%0d fc=%0d sc2=%0d exp %0d %0d %0d",
                         c, b1.stall_cnt, b1.flush_cnt, b2.stall_cnt,
                         m_sc, m_fc, m_sc2);
            end
            hold = st;
            m_clock();
            tick();
        end
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0);
        m_reset();
        tick();
        test_reset();
        test_lw_latency();
        test_load_use();
        test_branch();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
